// File: rtl/i2c_bit_engine_if.sv
// Command/status handshake between i2c_core and the bit engine, plus the
// open-drain pad pins. The engine sits on the slave side.
interface i2c_bit_engine_if #(
  parameter int DIV_WIDTH = 16
);
  logic [DIV_WIDTH-1:0] clk_divider;
  logic                 cmd_valid;
  logic [1:0]           cmd;
  logic                 cmd_bit;
  logic                 cmd_ready;
  logic                 done;
  logic                 rx_bit;
  logic                 arb_lost;
  logic                 bus_busy;
  logic                 scl_i;
  logic                 sda_i;
  logic                 scl_oe;
  logic                 sda_oe;

  modport master (
    output clk_divider, cmd_valid, cmd, cmd_bit, scl_i, sda_i,
    input  cmd_ready, done, rx_bit, arb_lost, bus_busy, scl_oe, sda_oe
  );

  modport slave (
    input  clk_divider, cmd_valid, cmd, cmd_bit, scl_i, sda_i,
    output cmd_ready, done, rx_bit, arb_lost, bus_busy, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_bit_engine.sv
// Bit-level I2C engine: runs one START/STOP/WRITE/READ command through four
// timed phases, driving open-drain SCL/SDA and watching for arbitration loss.
module i2c_bit_engine #(
  parameter int DIV_WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  i2c_bit_engine_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_C    = 3'd3,
    S_D    = 3'd4
  } state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [DIV_WIDTH-1:0] CNT_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [1:0]           cmd_q, cmd_d, settle_q, settle_d;
  logic [1:0]           scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                 bit_q, bit_d, scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic                 sda_oe_p1_q, sda_oe_p1_d, sda_oe_p2_q, sda_oe_p2_d;
  logic                 done_q, done_d, arb_lost_q, arb_lost_d, rx_bit_q, rx_bit_d;
  logic                 cmd_ready_q, cmd_ready_d, bus_busy_q, bus_busy_d;
  logic                 sda_prev_q, sda_prev_d;
  logic                 scl_s, sda_s, sda_rel_s, win_s, arb_hit_s;

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
  // SDA only counts as released once our own release has crossed the synchronizer.
  assign sda_rel_s = ~sda_oe_q & ~sda_oe_p1_q & ~sda_oe_p2_q;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.done      = done_q;
  assign bus.rx_bit    = rx_bit_q;
  assign bus.arb_lost  = arb_lost_q;
  assign bus.bus_busy  = bus_busy_q;
  assign bus.scl_oe    = scl_oe_q;
  assign bus.sda_oe    = sda_oe_q;

  // Returns {scl_oe, sda_oe} for the given phase; IDLE keeps the present drive.
  function automatic logic [1:0] phase_drive(input state_t st, input logic [1:0] c,
                                             input logic b, input logic scl_now,
                                             input logic sda_now);
    logic [1:0] drv;
    drv = {scl_now, sda_now};
    case (st)
      S_A: case (c)
        CMD_START: drv = {scl_now, 1'b0};
        CMD_STOP:  drv = 2'b11;
        CMD_WRITE: drv = {1'b1, ~b};
        default:   drv = 2'b10;
      endcase
      S_B: case (c)
        CMD_START: drv = 2'b00;
        CMD_STOP:  drv = 2'b01;
        CMD_WRITE: drv = {1'b0, ~b};
        default:   drv = 2'b00;
      endcase
      S_C: case (c)
        CMD_START: drv = 2'b01;
        CMD_STOP:  drv = 2'b00;
        CMD_WRITE: drv = {1'b0, ~b};
        default:   drv = 2'b00;
      endcase
      S_D: case (c)
        CMD_START: drv = 2'b11;
        CMD_STOP:  drv = 2'b00;
        CMD_WRITE: drv = {1'b1, ~b};
        default:   drv = 2'b10;
      endcase
      default: drv = {scl_now, sda_now};
    endcase
    return drv;
  endfunction

  // Next-state, phase counter, arbitration, bus monitor and output drive.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    cmd_d       = cmd_q;
    bit_d       = bit_q;
    settle_d    = settle_q;
    done_d      = 1'b0;
    arb_lost_d  = 1'b0;
    rx_bit_d    = rx_bit_q;
    scl_sync_d  = {scl_sync_q[0], bus.scl_i};
    sda_sync_d  = {sda_sync_q[0], bus.sda_i};
    sda_prev_d  = sda_s;
    sda_oe_p1_d = sda_oe_q;
    sda_oe_p2_d = sda_oe_p1_q;
    scl_oe_d    = scl_oe_q;
    sda_oe_d    = sda_oe_q;

    case (state_q)
      S_B:     win_s = (cmd_q == CMD_START && settle_q == 2'd0 && scl_s) ||
                       (cmd_q == CMD_WRITE && bit_q);
      S_C:     win_s = (cmd_q == CMD_WRITE && bit_q) || (cmd_q == CMD_STOP);
      S_D:     win_s = (cmd_q == CMD_STOP);
      default: win_s = 1'b0;
    endcase
    arb_hit_s = win_s & sda_rel_s & ~sda_s;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d = S_A;
          cmd_d   = bus.cmd;
          bit_d   = bus.cmd_bit;
          div_d   = bus.clk_divider;
          cnt_d   = bus.clk_divider;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_A: begin
        if (cnt_q == CNT_ZERO) begin
          state_d  = S_B;
          cnt_d    = div_q;
          settle_d = 2'd2;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_B: begin
        // Two settle cycles cover the sync delay of our own SCL release.
        if (settle_q != 2'd0) begin
          settle_d = settle_q - 2'd1;
          cnt_d    = div_q;
        end else if (!scl_s) begin
          cnt_d = div_q;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = S_C;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_C: begin
        if (cnt_q == CNT_ZERO) begin
          state_d  = S_D;
          cnt_d    = div_q;
          rx_bit_d = cmd_q[1] ? sda_s : rx_bit_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_D: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (arb_hit_s) begin
      state_d    = S_IDLE;
      arb_lost_d = 1'b1;
      done_d     = 1'b0;
      rx_bit_d   = rx_bit_q;
      scl_oe_d   = 1'b0;
      sda_oe_d   = 1'b0;
    end else begin
      {scl_oe_d, sda_oe_d} = phase_drive(state_d, cmd_d, bit_d, scl_oe_q, sda_oe_q);
    end

    cmd_ready_d = (state_d == S_IDLE);

    if (scl_s && sda_prev_q && !sda_s) begin
      bus_busy_d = 1'b1;
    end else if (scl_s && !sda_prev_q && sda_s) begin
      bus_busy_d = 1'b0;
    end else begin
      bus_busy_d = bus_busy_q;
    end
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= CNT_ZERO;
      div_q       <= CNT_ZERO;
      cmd_q       <= 2'b00;
      bit_q       <= 1'b0;
      settle_q    <= 2'd0;
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
      sda_prev_q  <= 1'b1;
      sda_oe_p1_q <= 1'b0;
      sda_oe_p2_q <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      done_q      <= 1'b0;
      arb_lost_q  <= 1'b0;
      rx_bit_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      bus_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      cmd_q       <= cmd_d;
      bit_q       <= bit_d;
      settle_q    <= settle_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      sda_prev_q  <= sda_prev_d;
      sda_oe_p1_q <= sda_oe_p1_d;
      sda_oe_p2_q <= sda_oe_p2_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
      done_q      <= done_d;
      arb_lost_q  <= arb_lost_d;
      rx_bit_q    <= rx_bit_d;
      cmd_ready_q <= cmd_ready_d;
      bus_busy_q  <= bus_busy_d;
    end
  end

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Directed bench for i2c_bit_engine: pads modelled as an ideal open-drain bus
// with optional SCL stretch and forced-low SDA from another master.
module tb_i2c_bit_engine;
  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  logic clk = 1'b0;
  logic reset;
  logic scl_hold, sda_low;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic       v_s [64];
  logic [1:0] c_s [64];
  logic       b_s [64];
  logic       h_s [64];
  logic       l_s [64];
  logic scl_h [64], sda_h [64], done_h [64], rdy_h [64], bb_h [64], rx_h [64];
  int   done_n, done_first, arb_n, arb_first;

  i2c_bit_engine_if #(.DIV_WIDTH(16)) bus ();
  i2c_bit_engine #(.DIV_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  assign bus.scl_i = ~bus.scl_oe & ~scl_hold;
  assign bus.sda_i = ~bus.sda_oe & ~sda_low;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sched();
    for (int k = 0; k < 64; k++) begin
      v_s[k] = 1'b0; c_s[k] = 2'b00; b_s[k] = 1'b0; h_s[k] = 1'b0; l_s[k] = 1'b0;
    end
  endtask

  // Applies schedule entry k in cycle k, records outputs, then advances a cycle.
  task automatic run(input int len);
    done_n = 0; done_first = -1; arb_n = 0; arb_first = -1;
    for (int k = 0; k < len; k++) begin
      bus.cmd_valid = v_s[k]; bus.cmd = c_s[k]; bus.cmd_bit = b_s[k];
      scl_hold = h_s[k]; sda_low = l_s[k];
      scl_h[k] = bus.scl_oe; sda_h[k] = bus.sda_oe; done_h[k] = bus.done;
      rdy_h[k] = bus.cmd_ready; bb_h[k] = bus.bus_busy; rx_h[k] = bus.rx_bit;
      if (bus.done) begin
        done_n++;
        if (done_first < 0) done_first = k;
      end
      if (bus.arb_lost) begin
        arb_n++;
        if (arb_first < 0) arb_first = k;
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; scl_hold = 1'b0; sda_low = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd = 2'b00; bus.cmd_bit = 1'b0; bus.clk_divider = 16'd3;
    clear_sched();
    repeat (2) @(posedge clk);
    #1;
    check("rst_scl_oe", bus.scl_oe, 1'b0);
    check("rst_sda_oe", bus.sda_oe, 1'b0);
    check("rst_ready", bus.cmd_ready, 1'b1);
    check("rst_done", bus.done, 1'b0);
    check("rst_rx", bus.rx_bit, 1'b0);
    check("rst_arb", bus.arb_lost, 1'b0);
    check("rst_busy", bus.bus_busy, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a WRITE 0 must release both lines at once
    clear_sched(); v_s[0] = 1'b1; c_s[0] = C_WRITE; b_s[0] = 1'b0;
    run(4);
    check("midw_scl_a", bus.scl_oe, 1'b1);
    check("midw_sda_a", bus.sda_oe, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_scl", bus.scl_oe, 1'b0);
    check("async_sda", bus.sda_oe, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", bus.cmd_ready, 1'b1);
    check("post_rst_busy", bus.bus_busy, 1'b0);

    // START, D=3, from an idle bus
    clear_sched(); v_s[0] = 1'b1; c_s[0] = C_START;
    run(24);
    check("start_done_cyc", done_first, 19);
    check("start_done_n", done_n, 1);
    check("start_arb_n", arb_n, 0);
    check("start_rdy1", rdy_h[1], 1'b0);
    check("start_rdy19", rdy_h[19], 1'b1);
    check("start_ab", {scl_h[4], sda_h[4], scl_h[10], sda_h[10]}, 4'b0000);
    check("start_c", {scl_h[11], sda_h[11], scl_h[14], sda_h[14]}, 4'b0101);
    check("start_d", {scl_h[15], sda_h[15], scl_h[23], sda_h[23]}, 4'b1111);
    check("start_busy10", bb_h[10], 1'b0);
    check("start_busy14", bb_h[14], 1'b1);

    // WRITE 1 with SDA forced low from phase B: arbitration lost
    clear_sched(); v_s[0] = 1'b1; c_s[0] = C_WRITE; b_s[0] = 1'b1;
    for (int k = 5; k < 24; k++) l_s[k] = 1'b1;
    run(24);
    check("arb_n", arb_n, 1);
    check("arb_cyc", arb_first, 8);
    check("arb_done_n", done_n, 0);
    check("arb_a", {scl_h[4], sda_h[4]}, 2'b10);
    check("arb_lines", {scl_h[8], sda_h[8]}, 2'b00);
    check("arb_ready", rdy_h[8], 1'b1);

    // Other master releases SDA with SCL high: looks like a STOP
    clear_sched();
    run(8);
    check("rel_busy0", bb_h[0], 1'b1);
    check("rel_busy5", bb_h[5], 1'b0);

    // READ with SDA low and 10 extra stretch cycles in B
    clear_sched(); v_s[0] = 1'b1; c_s[0] = C_READ;
    for (int k = 4; k < 34; k++) l_s[k] = 1'b1;
    for (int k = 5; k < 15; k++) h_s[k] = 1'b1;
    run(34);
    check("rd0_done_cyc", done_first, 29);
    check("rd0_rx", rx_h[29], 1'b0);
    check("rd0_scl", {scl_h[4], scl_h[5], scl_h[24], scl_h[25]}, 4'b1001);
    check("rd0_sda", sda_h[12], 1'b0);

    // Same READ with SDA high
    clear_sched(); v_s[0] = 1'b1; c_s[0] = C_READ;
    for (int k = 5; k < 15; k++) h_s[k] = 1'b1;
    run(34);
    check("rd1_done_cyc", done_first, 29);
    check("rd1_rx_hold", rx_h[24], 1'b0);
    check("rd1_rx", rx_h[29], 1'b1);

    // Repeated START from SCL low: SCL keeps its low drive in phase A
    clear_sched(); v_s[0] = 1'b1; c_s[0] = C_START;
    run(24);
    check("rs_done_cyc", done_first, 19);
    check("rs_scl_a", scl_h[3], 1'b1);
    check("rs_busy", bb_h[19], 1'b1);

    // STOP with an ignored cmd_valid pulse mid-command
    clear_sched(); v_s[0] = 1'b1; c_s[0] = C_STOP;
    v_s[8] = 1'b1; c_s[8] = C_START;
    run(40);
    check("stop_done_n", done_n, 1);
    check("stop_done_cyc", done_first, 19);
    check("stop_arb_n", arb_n, 0);
    check("stop_lines", {scl_h[4], sda_h[4], scl_h[5], sda_h[10], sda_h[11]}, 5'b11010);
    check("stop_busy13", bb_h[13], 1'b1);
    check("stop_busy18", bb_h[18], 1'b0);
    check("stop_idle", {scl_h[39], sda_h[39]}, 2'b00);

    // D=0 back-to-back START, WRITE 0, STOP
    bus.clk_divider = 16'd0;
    clear_sched();
    for (int k = 0; k < 15; k++) v_s[k] = 1'b1;
    for (int k = 7; k < 14; k++) c_s[k] = C_WRITE;
    c_s[14] = C_STOP;
    run(26);
    check("d0_done_n", done_n, 3);
    check("d0_done", {done_h[7], done_h[14], done_h[21], done_h[13]}, 4'b1110);
    check("d0_start", {scl_h[4], sda_h[4], scl_h[5], sda_h[5], scl_h[6], sda_h[6]}, 6'b000111);
    check("d0_write", {scl_h[8], sda_h[8], scl_h[9], sda_h[11], scl_h[12], scl_h[13]}, 6'b110101);
    check("d0_stop", {scl_h[15], scl_h[18], sda_h[18], scl_h[19], sda_h[19], sda_h[25]}, 6'b101000);
    check("d0_rx", rx_h[13], 1'b0);
    check("d0_busy", {bb_h[10], bb_h[23]}, 2'b10);
    check("d0_ready", {rdy_h[15], rdy_h[22]}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_bit_engine.md
# i2c_bit_engine

Bit-level I2C bus engine that sits directly downstream of `i2c_core`. It accepts one bus command at a time (START, STOP, WRITE bit, READ bit) and generates open-drain SCL/SDA timing from the core's `clk_divider`. It reports completion, the sampled bit, arbitration loss and bus-busy status back to the core. Byte sequencing, ACK policy, FIFOs and interrupts stay in `i2c_core`.

## Interface
- `DIV_WIDTH`, default 16: width of `clk_divider`.
- `clk  in  1`: peripheral clock; all logic on the rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `clk_divider  in  DIV_WIDTH`: phase length minus 1 (D); each phase lasts D+1 cycles.
- `cmd_valid  in  1`: command request.
- `cmd  in  2`: 00 START, 01 STOP, 10 WRITE, 11 READ.
- `cmd_bit  in  1`: bit driven for WRITE (also used for master ACK/NACK).
- `cmd_ready  out  1`: high when IDLE; accept occurs on `cmd_valid && cmd_ready`.
- `done  out  1`: one-cycle pulse when a command completes normally.
- `rx_bit  out  1`: SDA sampled at the end of phase C of WRITE/READ; holds until the next sample.
- `arb_lost  out  1`: one-cycle pulse on arbitration loss.
- `bus_busy  out  1`: bus-level START seen and no STOP since.
- `scl_i, sda_i  in  1`: pad inputs.
- `scl_oe, sda_oe  out  1`: registered open-drain enables; 1 pulls the line low.

## Operation
- **Inputs:** two-flop synchronizers on `scl_i` and `sda_i`, reset to 1. All detection uses the synced values `scl_s` and `sda_s`.
- **States:** IDLE, A, B, C, D.
  - On accept, latch `cmd`, `cmd_bit` and D, then go to A. Changes to `clk_divider` during a command are ignored.
  - A→B→C→D→IDLE, each phase D+1 cycles via a down-counter.
- **Clock stretching:** in B the counter is held at D until `scl_s`=1, then it counts.
- **Line drive per phase (A/B/C/D):**
  - START: SDA released in A and B, low in C and D. SCL holds its previous value in A, released in B and C, low in D.
  - STOP: SDA low in A and B, released in C and D. SCL low in A, released in B, C and D.
  - WRITE: `sda_oe`=~`cmd_bit` in all phases. SCL low in A, released in B and C, low in D.
  - READ: SDA released in all phases. SCL as WRITE.
- **Idle drive:** both enables keep their phase-D values. SCL stays low after START/WRITE/READ and is released after STOP.
- **Arbitration loss:** triggered when SDA is released and `sda_s`=0 during any of these windows:
  - START phase B (after the stretch wait);
  - WRITE phases B/C with `cmd_bit`=1;
  - STOP phases C/D.
  
  On loss: `scl_oe`=`sda_oe`=0, pulse `arb_lost`, go to IDLE, no `done`.
- **Bus monitor:** independent of the FSM, including traffic from other masters.
  - `sda_s` falling while `scl_s`=1 sets `bus_busy`.
  - `sda_s` rising while `scl_s`=1 clears it.
  - Updates one cycle after the synced edge.
- **Command rules:** `cmd_valid` while not ready is ignored; there is no queue.

## Timing
- **Reset values:** `scl_oe`=0, `sda_oe`=0, `cmd_ready`=1, `done`=0, `rx_bit`=0, `arb_lost`=0, `bus_busy`=0, state IDLE.
- **Reset mid-command:** lines are released immediately (asynchronous); the command is aborted silently.
- **Accept to first drive:** accept in cycle T; phase-A drive is visible at T+1.
- **Duration, ideal bus** (`scl_i`=~`scl_oe`, `sda_i`=~`sda_oe`, combinational): B lasts D+3 cycles because of the 2-cycle sync delay. The command spans 4(D+1)+2 cycles.
- **Completion:** `done` and `cmd_ready` go high together in cycle T+4(D+1)+3.
- **Stretch extension:** each additional cycle that `scl_s` stays low in B adds exactly one cycle.
- **`rx_bit`:** updates on the last cycle of C and is valid no later than `done`.
- **`arb_lost`:** pulses the cycle after `sda_s`=0 is observed in a check window; `cmd_ready` is high the following cycle.
- **Minimum divider:** D=0 is legal (1-cycle phases). The counter must not wrap.
- **Back-to-back commands:** `cmd_valid` held high restarts at A the cycle after `done`.

## Test plan
- **Reset:** assert `reset` mid-WRITE with D=3 → `scl_oe`/`sda_oe` drop to 0 asynchronously; after release `cmd_ready`=1 and `bus_busy`=0.
- **START on ideal bus, D=3:** `done` 19 cycles after accept. SDA falls while SCL is high, then SCL goes low. `bus_busy`=1 within 3 cycles of the SDA fall.
- **WRITE `cmd_bit`=1 on ideal bus, with `sda_i` forced 0 from phase B:** single `arb_lost` pulse, both enables 0, no `done`, `cmd_ready`=1 the next cycle.
- **READ with D=3, `sda_i`=0, `scl_i` held low 10 extra cycles in B:** `done` at cycle 29 after accept, `rx_bit`=0. Repeat with `sda_i`=1 → `rx_bit`=1.
- **STOP after START:** `bus_busy` clears. A `cmd_valid` pulse mid-STOP is ignored; exactly one `done`.
- **D=0 back-to-back START, WRITE 0, STOP:** each command takes 6 cycles. Correct line sequence and no counter wrap.
